// File: rtl/bsg_arb_wrr_pkg.sv
// Shared types and constants for the weighted, packet-locking round-robin arbiter.
package bsg_arb_wrr_pkg;

  typedef enum logic {e_idle, e_locked} bsg_arb_wrr_state_e;

  localparam int bsg_arb_wrr_timeout_gp = 255;

endpackage

// File: rtl/bsg_arb_wrr_rot_pick.sv
// Rotating priority search: first set request at or above ptr_i, wrapping to 0.
module bsg_arb_wrr_rot_pick
  import bsg_arb_wrr_pkg::*;
#(
  parameter int inputs_p     = 32,
  parameter int lg_inputs_lp = $clog2(inputs_p)
) (
  input  logic [inputs_p-1:0]     reqs_i,
  input  logic [lg_inputs_lp-1:0] ptr_i,
  output logic [inputs_p-1:0]     grants_o,
  output logic [lg_inputs_lp-1:0] tag_o,
  output logic                    v_o
);

  localparam logic [lg_inputs_lp:0] inputs_lp = (lg_inputs_lp+1)'(inputs_p);
  localparam logic [inputs_p-1:0]   one_lp    = inputs_p'(1);

  logic [inputs_p-1:0]     rot;
  logic [lg_inputs_lp-1:0] off;
  logic [lg_inputs_lp:0]   sum;

  // Doubling the vector turns the wrap-around search into a plain shift.
  assign rot = inputs_p'({reqs_i, reqs_i} >> ptr_i);

  always_comb begin
    off = '0;
    for (int i = inputs_p - 1; i >= 0; i--) begin
      if (rot[i]) off = lg_inputs_lp'(i);
    end
  end

  assign sum      = {1'b0, ptr_i} + {1'b0, off};
  assign tag_o    = (sum >= inputs_lp) ? lg_inputs_lp'(sum - inputs_lp) : lg_inputs_lp'(sum);
  assign v_o      = |reqs_i;
  assign grants_o = v_o ? (one_lp << tag_o) : '0;

endmodule

// File: rtl/bsg_arb_wrr_lock.sv
// Weighted, packet-locking round-robin arbiter.
// Optional lock timeout enabled by defining BSG_ARB_WRR_LOCK_TIMEOUT_EN.
module bsg_arb_wrr_lock
  import bsg_arb_wrr_pkg::*;
#(
  parameter int inputs_p       = 32,
  parameter int weight_width_p = 4,
  parameter int lg_inputs_lp   = $clog2(inputs_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [inputs_p-1:0]       reqs_i,
  output logic [inputs_p-1:0]       grants_o,
  output logic [lg_inputs_lp-1:0]   tag_o,
  output logic                      v_o,
  input  logic                      yumi_i,
  input  logic                      last_i,
  input  logic                      cfg_v_i,
  input  logic [lg_inputs_lp-1:0]   cfg_idx_i,
  input  logic [weight_width_p-1:0] cfg_weight_i,
  output logic                      timeout_o
);

  localparam logic [inputs_p-1:0]     one_lp      = inputs_p'(1);
  localparam logic [lg_inputs_lp-1:0] last_idx_lp = lg_inputs_lp'(inputs_p - 1);

  bsg_arb_wrr_state_e state_q, state_d;
  logic [lg_inputs_lp-1:0]   hold_q, hold_d;
  logic [lg_inputs_lp-1:0]   ptr_q, ptr_d;
  logic [weight_width_p-1:0] cnt_q, cnt_d;
  logic                      burst_v_q, burst_v_d;
  logic [lg_inputs_lp-1:0]   burst_idx_q, burst_idx_d;
  logic [weight_width_p-1:0] weight_q [inputs_p];

  logic [inputs_p-1:0]       pick_grants;
  logic [lg_inputs_lp-1:0]   pick_tag;
  logic                      pick_v;

  logic                      locked;
  logic                      sel_v;
  logic [lg_inputs_lp-1:0]   sel_tag;
  logic [inputs_p-1:0]       sel_grants;

  logic                      fire;
  logic                      done;
  logic [lg_inputs_lp-1:0]   done_idx;
  logic [weight_width_p:0]   n_cnt;
  logic [weight_width_p-1:0] w_eff;

  bsg_arb_wrr_rot_pick #(
    .inputs_p    (inputs_p),
    .lg_inputs_lp(lg_inputs_lp)
  ) rot_pick (
    .reqs_i  (reqs_i),
    .ptr_i   (ptr_q),
    .grants_o(pick_grants),
    .tag_o   (pick_tag),
    .v_o     (pick_v)
  );

  assign locked     = (state_q == e_locked);
  assign sel_v      = locked ? reqs_i[hold_q] : pick_v;
  assign sel_tag    = locked ? hold_q : pick_tag;
  assign sel_grants = locked ? (reqs_i[hold_q] ? (one_lp << hold_q) : '0) : pick_grants;

  assign v_o      = reset_n_i & sel_v;
  assign tag_o    = (reset_n_i & sel_v) ? sel_tag : '0;
  assign grants_o = reset_n_i ? sel_grants : '0;

  // A forced release completes the packet on behalf of the lock holder.
  assign done     = fire | (yumi_i & last_i);
  assign done_idx = fire ? hold_q : sel_tag;
  assign n_cnt    = (burst_v_q && (burst_idx_q == done_idx))
                  ? ({1'b0, cnt_q} + (weight_width_p+1)'(1))
                  : (weight_width_p+1)'(1);
  assign w_eff    = (weight_q[done_idx] == '0) ? weight_width_p'(1) : weight_q[done_idx];

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    burst_v_d   = burst_v_q;
    burst_idx_d = burst_idx_q;
    if (done) begin
      state_d = e_idle;
      if (n_cnt >= {1'b0, w_eff}) begin
        ptr_d     = (done_idx == last_idx_lp) ? '0 : done_idx + lg_inputs_lp'(1);
        cnt_d     = '0;
        burst_v_d = 1'b0;
      end else begin
        ptr_d       = done_idx;
        cnt_d       = n_cnt[weight_width_p-1:0];
        burst_v_d   = 1'b1;
        burst_idx_d = done_idx;
      end
    end else if (yumi_i) begin
      state_d = e_locked;
      hold_d  = sel_tag;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q     <= e_idle;
      hold_q      <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      burst_v_q   <= 1'b0;
      burst_idx_q <= '0;
      for (int i = 0; i < inputs_p; i++) weight_q[i] <= weight_width_p'(1);
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      burst_v_q   <= burst_v_d;
      burst_idx_q <= burst_idx_d;
      if (cfg_v_i) weight_q[cfg_idx_i] <= cfg_weight_i;
    end
  end

`ifdef BSG_ARB_WRR_LOCK_TIMEOUT_EN
  logic [7:0] to_cnt_q, to_cnt_d;
  logic       timeout_q;

  // Counts idle cycles of the lock holder; saturation releases the lock.
  assign fire     = locked && (to_cnt_q == 8'(bsg_arb_wrr_timeout_gp));
  assign to_cnt_d = (locked && !fire && !reqs_i[hold_q]) ? to_cnt_q + 8'd1 : 8'd0;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      to_cnt_q  <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= fire;
    end
  end

  assign timeout_o = reset_n_i & timeout_q;
`else
  assign fire      = 1'b0;
  assign timeout_o = 1'b0;
`endif

  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);

endmodule

// File: tb/tb_bsg_arb_wrr_lock.sv
// Randomized and directed bench for bsg_arb_wrr_lock against a behavioural model.
// Timeout scenario is exercised when BSG_ARB_WRR_LOCK_TIMEOUT_EN is defined.
module tb_bsg_arb_wrr_lock;

  localparam int N  = 32;
  localparam int W  = 4;
  localparam int LG = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  reqs;
  logic [N-1:0]  grants;
  logic [LG-1:0] tag;
  logic          v;
  logic          yumi;
  logic          last;
  logic          cfgV;
  logic [LG-1:0] cfgIdx;
  logic [W-1:0]  cfgWeight;
  logic          timeout;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit mLocked;
  int mHold;
  int mPtr;
  int mCnt;
  bit mBurstV;
  int mBurstIdx;
  int mWeight [N];
  int mTo;
  bit mPulse;

  logic [31:0] obsTag;
  logic [31:0] obsV;
  logic [31:0] obsTimeout;

  always #5 clk = ~clk;

  bsg_arb_wrr_lock #(.inputs_p(N), .weight_width_p(W)) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .reqs_i      (reqs),
    .grants_o    (grants),
    .tag_o       (tag),
    .v_o         (v),
    .yumi_i      (yumi),
    .last_i      (last),
    .cfg_v_i     (cfgV),
    .cfg_idx_i   (cfgIdx),
    .cfg_weight_i(cfgWeight),
    .timeout_o   (timeout)
  );

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic void modelReset();
    mLocked = 0; mHold = 0; mPtr = 0; mCnt = 0; mBurstV = 0; mBurstIdx = 0;
    mTo = 0; mPulse = 0;
    for (int i = 0; i < N; i++) mWeight[i] = 1;
  endfunction

  function automatic void modelPick(input logic [N-1:0] r, output bit ev, output int et);
    ev = 0;
    et = 0;
    if (mLocked) begin
      ev = r[mHold];
      et = ev ? mHold : 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!ev && r[(mPtr + i) % N]) begin
          ev = 1;
          et = (mPtr + i) % N;
        end
      end
    end
  endfunction

  function automatic void modelComplete(input int g);
    int n;
    int w;
    n = (mBurstV && mBurstIdx == g) ? mCnt + 1 : 1;
    w = (mWeight[g] == 0) ? 1 : mWeight[g];
    if (n >= w) begin
      mPtr = (g + 1) % N; mCnt = 0; mBurstV = 0;
    end else begin
      mPtr = g; mCnt = n; mBurstV = 1; mBurstIdx = g;
    end
  endfunction

  function automatic void modelStep(input logic [N-1:0] r, input bit y, input bit l,
                                    input bit cV, input logic [LG-1:0] cIdx,
                                    input logic [W-1:0] cW, input int et);
    bit fire;
    bit prevLocked;
    int prevHold;
    fire = 0;
    prevLocked = mLocked;
    prevHold = mHold;
`ifdef BSG_ARB_WRR_LOCK_TIMEOUT_EN
    fire = mLocked && (mTo == 255);
`endif
    mPulse = fire;
    if (fire) begin
      mLocked = 0;
      modelComplete(mHold);
    end else if (y) begin
      if (l) begin
        mLocked = 0;
        modelComplete(et);
      end else begin
        mLocked = 1;
        mHold = et;
      end
    end
    mTo = (prevLocked && !fire && !r[prevHold]) ? mTo + 1 : 0;
    if (cV) mWeight[cIdx] = int'(cW);
  endfunction

  // One cycle: drive, check combinational outputs, clock, advance the model.
  task automatic applyStimulus(input logic [N-1:0] r, input bit wantYumi, input bit l,
                               input bit cV, input logic [LG-1:0] cIdx, input logic [W-1:0] cW);
    bit ev;
    int et;
    reqs = r; last = l; cfgV = cV; cfgIdx = cIdx; cfgWeight = cW;
    modelPick(r, ev, et);
    yumi = wantYumi && ev;
    #1;
    obsTag = 32'(tag);
    obsV = 32'(v);
    obsTimeout = 32'(timeout);
    checkOutput("v", obsV, 32'(ev));
    checkOutput("tag", obsTag, 32'(et));
    checkOutput("grants", grants, ev ? (32'd1 << et) : 32'd0);
    checkOutput("timeout", obsTimeout, 32'(mPulse));
    @(posedge clk);
    modelStep(r, yumi, l, cV, cIdx, cW, et);
    @(negedge clk);
  endtask

  task automatic resetCycles(input int n);
    reset_n = 1'b0;
    reqs = 32'h0000_0005; yumi = 1'b0; last = 1'b0; cfgV = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1;
      checkOutput("rst_v", 32'(v), 32'd0);
      checkOutput("rst_grants", grants, 32'd0);
      checkOutput("rst_tag", 32'(tag), 32'd0);
      checkOutput("rst_timeout", 32'(timeout), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    modelReset();
    reset_n = 1'b1;
  endtask

  initial begin
    int expW[8];
    int timeouts;
    expW = '{3, 3, 3, 4, 3, 3, 3, 4};
    reset_n = 1'b0; reqs = '0; yumi = 1'b0; last = 1'b0;
    cfgV = 1'b0; cfgIdx = '0; cfgWeight = '0;
    modelReset();
    @(negedge clk);
    resetCycles(3);

    // Reset defaults: alternate 0 and 2
    for (int i = 0; i < 8; i++) begin
      applyStimulus(32'h0000_0005, 1, 1, 0, '0, '0);
      checkOutput("dflt_seq", obsTag, (i % 2) ? 32'd2 : 32'd0);
    end

    // Weight 3 on requester 3
    resetCycles(1);
    applyStimulus(32'h0, 0, 0, 1, 5'd3, 4'd3);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(32'h0000_0018, 1, 1, 0, '0, '0);
      checkOutput("wt_seq", obsTag, 32'(expW[i]));
    end

    // Four-beat lock on 1 with 0 also requesting
    resetCycles(1);
    applyStimulus(32'h0000_0001, 1, 1, 0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(32'h0000_0003, 1, (i == 3), 0, '0, '0);
      checkOutput("lock_seq", obsTag, 32'd1);
    end
    applyStimulus(32'h0000_0003, 0, 0, 0, '0, '0);
    checkOutput("lock_after", obsTag, 32'd0);

    // Holder drops its request mid-packet
    resetCycles(1);
    applyStimulus(32'h0000_0001, 1, 1, 0, '0, '0);
    applyStimulus(32'h0000_0003, 1, 0, 0, '0, '0);
    applyStimulus(32'h0000_0001, 0, 0, 0, '0, '0);
    checkOutput("drop_v", obsV, 32'd0);
    applyStimulus(32'h0000_0003, 1, 1, 0, '0, '0);
    checkOutput("drop_resume", obsTag, 32'd1);

    // Wrap with zero weight on 31
    resetCycles(1);
    applyStimulus(32'h4000_0000, 1, 1, 1, 5'd31, 4'd0);
    applyStimulus(32'h8000_0001, 1, 1, 0, '0, '0);
    checkOutput("wrap_31", obsTag, 32'd31);
    applyStimulus(32'h8000_0001, 1, 1, 0, '0, '0);
    checkOutput("wrap_0", obsTag, 32'd0);

    // Weight write concurrent with the first completion of a weight-2 burst
    resetCycles(1);
    applyStimulus(32'h0, 0, 0, 1, 5'd2, 4'd2);
    applyStimulus(32'h0000_000C, 1, 1, 1, 5'd2, 4'd1);
    checkOutput("cc_first", obsTag, 32'd2);
    applyStimulus(32'h0000_000C, 1, 1, 0, '0, '0);
    checkOutput("cc_second", obsTag, 32'd2);
    applyStimulus(32'h0000_000C, 1, 1, 0, '0, '0);
    checkOutput("cc_rotate", obsTag, 32'd3);

    // Reset in the middle of a packet drops the lock
    applyStimulus(32'h0000_0010, 1, 0, 0, '0, '0);
    resetCycles(1);
    applyStimulus(32'h0000_0011, 0, 0, 0, '0, '0);
    checkOutput("rst_unlock", obsTag, 32'd0);

`ifdef BSG_ARB_WRR_LOCK_TIMEOUT_EN
    resetCycles(1);
    applyStimulus(32'h0000_0020, 1, 0, 0, '0, '0);
    timeouts = 0;
    for (int i = 0; i < 258; i++) begin
      applyStimulus(32'h0000_0041, 0, 0, 0, '0, '0);
      timeouts += obsTimeout;
    end
    checkOutput("to_pulses", 32'(timeouts), 32'd1);
    applyStimulus(32'h0000_0041, 1, 1, 0, '0, '0);
    checkOutput("to_next", obsTag, 32'd6);
`else
    timeouts = 0;
`endif

    // Randomized traffic
    resetCycles(1);
    for (int i = 0; i < 1500; i++) begin
      logic [N-1:0] r;
      if (i == 750) resetCycles(1);
      r = $urandom_range(0, 1) ? ($urandom & 32'h0000_00FF) : ($urandom & $urandom);
      applyStimulus(r, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 15) == 0, LG'($urandom_range(0, N - 1)),
                    W'($urandom_range(0, 4)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bsg_arb_wrr_lock.md
# bsg_arb_wrr_lock

Weighted, packet-locking round-robin arbiter that shares one downstream channel among `inputs_p` requesters. Arbitration is per packet: once a grant is accepted, the winner keeps the channel until it signals its last beat. Each requester may take up to a programmable number of consecutive packets, set by its weight, before priority rotates. The block sits in front of a shared link or memory port and owns all sequencing of that resource.

## Interface
Parameters
- `inputs_p`, 32, number of requesters (≥2)
- `weight_width_p`, 4, width of each per-requester weight
- `lg_inputs_lp`, `$clog2(inputs_p)`, derived; not overridden

Ports
- `clk_i`  in  1  sole clock
- `reset_n_i`  in  1  reset, synchronous, active-low
- `reqs_i`  in  inputs_p  request vector, one bit per requester
- `grants_o`  out  inputs_p  one-hot grant; all-zero when `v_o`=0
- `tag_o`  out  lg_inputs_lp  binary index of the granted requester; 0 when `v_o`=0
- `v_o`  out  1  a grant is offered this cycle
- `yumi_i`  in  1  downstream accepts the granted beat this cycle; legal only when `v_o`=1
- `last_i`  in  1  the accepted beat is the final beat of a packet; qualified by `yumi_i`
- `cfg_v_i`  in  1  weight-table write strobe
- `cfg_idx_i`  in  lg_inputs_lp  weight-table write index
- `cfg_weight_i`  in  weight_width_p  weight value to write
- `timeout_o`  out  1  one-cycle pulse when a lock is forcibly released (see Configuration)

## Operation
- State: `IDLE` (arbitrating) or `LOCKED` (holding `hold_idx_r`). Additional registers:
  - `ptr_r`: priority pointer
  - `cnt_r`: packets already granted in the current burst
  - `burst_v_r`/`burst_idx_r`: the requester that owns the current burst
  - `weight_r[inputs_p]`
- In `IDLE`:
  - The winner is the first set bit of `reqs_i`, searching from `ptr_r` upward and wrapping from `inputs_p-1` to 0.
  - `v_o` = OR of `reqs_i`.
- In `LOCKED`:
  - `grants_o` is one-hot at `hold_idx_r` and `tag_o`=`hold_idx_r`.
  - `v_o`=`reqs_i[hold_idx_r]`.
  - All other requests are ignored.
- `yumi_i & ~last_i`: the state moves to `LOCKED` with `hold_idx_r`←`tag_o`. If the state is already `LOCKED`, it stays `LOCKED`.
- `yumi_i & last_i` (packet done, winner g): the state moves to `IDLE`, then the burst is updated:
  - Compute `n` = (`burst_v_r` & `burst_idx_r`==g) ? `cnt_r`+1 : 1.
  - Compute `w` = max(`weight_r[g]`, 1); a weight of 0 is treated as 1.
  - If `n` ≥ `w`: `ptr_r`←(g+1) mod `inputs_p`, `cnt_r`←0, `burst_v_r`←0.
  - Otherwise: `ptr_r`←g, `cnt_r`←`n`, `burst_v_r`←1, `burst_idx_r`←g.
- A single-beat packet is `yumi_i & last_i` in `IDLE`. No lock is taken; only the burst update applies.
- If a burst owner drops its request in `IDLE`, the search moves on from `ptr_r`. When another requester wins and completes a packet, that requester's own count restarts at 1.
- `cfg_v_i` writes `weight_r[cfg_idx_i]`, and the new value is visible the next cycle.
- If a packet completes in the same cycle as a weight write, the completion uses the old registered weight.
- If a weight is lowered mid-burst below `cnt_r`, rotation happens at the holder's next completion.
- `yumi_i` while `v_o`=0 is illegal. An assertion fires; the state update is undefined.

## Timing
- Request-to-grant path is combinational, with zero cycles of latency. `yumi_i`, `last_i` and `cfg_*` are sampled at the rising edge.
- Reset (`reset_n_i`=0 at an edge) sets:
  - state `IDLE`, `ptr_r`=0, `cnt_r`=0, `burst_v_r`=0, `burst_idx_r`=0
  - every `weight_r`=1
  - timeout counter 0
- While `reset_n_i`=0, the outputs are forced: `v_o`=0, `grants_o`=0, `tag_o`=0, `timeout_o`=0.
- A reset asserted mid-packet drops the lock immediately. No partial-packet state survives.
- A new grant to another requester is possible in the cycle after the `yumi_i & last_i` edge.

## Configuration
- `BSG_ARB_WRR_LOCK_TIMEOUT_EN` defined: an 8-bit counter runs in `LOCKED`.
  - It increments each cycle `reqs_i[hold_idx_r]`=0 and clears whenever that request is high or the state leaves `LOCKED`.
  - When it reaches 255, the next edge forces the state to `IDLE` and performs the same burst update as a `last_i` completion for `hold_idx_r`.
  - `timeout_o` pulses for 1 cycle after that edge, and the counter returns to 0.
- Not defined: there is no counter, `timeout_o` is tied to 0, and a lock holds indefinitely.

## Structure
- Shared package `bsg_arb_wrr_pkg`:
  - state enum `bsg_arb_wrr_state_e {e_idle, e_locked}`
  - timeout constant `bsg_arb_wrr_timeout_gp`=255
- Sub-module `bsg_arb_wrr_rot_pick`: combinational rotating priority search that takes `reqs_i` and `ptr_r` and returns one-hot, tag and valid. It is implemented as a doubled-vector priority encode.

## Test plan
- Reset defaults: reqs=0x0000_0005, every packet single-beat, yumi every cycle → tags 0,2,0,2…; `v_o`=0 during reset.
- Weight: write weight[3]=3; reqs=0x0000_0018, single-beat packets → tags 3,3,3,4,3,3,3,4…
- Lock: reqs=0x0000_0003; index 1 wins a 4-beat packet, `last_i` on beat 4; req[0] high throughout → grant stays on 1 for 4 beats, then goes to 0. If req[1] drops mid-packet → `v_o`=0, no grant to 0.
- Wrap and zero weight: weight[31]=0, ptr at 31, reqs=0x8000_0001 → 31 gets one packet, then 0.
- Concurrent write/completion: write weight[2]=1 in the same cycle as completion of the 1st packet of a weight-2 burst on 2 → 2 is granted again once (old weight), then rotates.
- With `BSG_ARB_WRR_LOCK_TIMEOUT_EN`: lock on 5, then drop req[5] for 255 cycles → `timeout_o` pulses once, next winner is searched from 6.
